mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the processor's single unified instruction/data memory between the multi-cycle CPU (controller/datapath memory port) and a secondary DMA/loader master. It sits between both masters and the memory. It serialises accesses with round-robin fairness and returns per-requester acknowledge and read data. The CPU controller uses `cpu_ack` to hold its fetch/load/store state until the access completes.

---
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one asynchronous-read memory
// between the CPU memory port and a DMA/loader master. Each access takes
// IDLE -> ACCESS (strobe) -> RESP (ack), giving one access per 3 cycles.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_adr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant_dma,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   grant;     // a winner is chosen this IDLE cycle
  logic   pick_dma;  // winner is DMA
  logic   we_q;      // latched write enable of the current access
  logic   last_dma;  // round-robin pointer: 1 = DMA won most recently

  // Next-state and arbitration decision; requests only matter in IDLE.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    pick_dma = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          grant    = 1'b1;
          pick_dma = dma_req && (!cpu_req || !last_dma);
          state_nx = ACCESS;
        end
      end
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Latch the winner's command and update the round-robin pointer on grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_adr   <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      grant_dma <= 1'b0;
      last_dma  <= 1'b1;
    end else if (grant) begin
      mem_adr   <= pick_dma ? dma_adr   : cpu_adr;
      mem_wdata <= pick_dma ? dma_wdata : cpu_wdata;
      we_q      <= pick_dma ? dma_we    : cpu_we;
      grant_dma <= pick_dma;
      last_dma  <= pick_dma;
    end
  end

  // Capture read data into the winner's register at the end of ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else if (state == ACCESS && !we_q) begin
      if (grant_dma) dma_rdata <= mem_rdata;
      else           cpu_rdata <= mem_rdata;
    end
  end

  // Strobes, acks and busy are decoded from the registered state.
  always_comb begin
    mem_read  = (state == ACCESS) && !we_q;
    mem_write = (state == ACCESS) &&  we_q;
    cpu_ack   = (state == RESP)   && !grant_dma;
    dma_ack   = (state == RESP)   &&  grant_dma;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks with inline checks plus an ack-driven
// scoreboard that checks owner and read data of every completed access.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_adr, cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        dma_req, dma_we;
  logic [31:0] dma_adr, dma_wdata, dma_rdata;
  logic        dma_ack;
  logic        mem_read, mem_write;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic        grant_dma, busy;

  int n_cmp = 0;
  int n_err = 0;

  // Environment memory (word addressed by adr[9:2]) and the bench's own copy.
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  typedef struct {
    logic        is_dma;
    logic        we;
    logic [31:0] rdata;
  } exp_t;
  exp_t        sb[$];
  exp_t        sb_e;
  logic [31:0] sb_got;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .grant_dma(grant_dma), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_adr[9:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_adr[9:2]] <= mem_wdata;
  end

  // Scoreboard: every ack pops the oldest expected access.
  always @(negedge clk) begin
    if (rst === 1'b1 && (cpu_ack === 1'b1 || dma_ack === 1'b1)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_ack: got cpu_ack=%b dma_ack=%b, required no ack", cpu_ack, dma_ack);
      end else begin
        sb_e = sb.pop_front();
        if ({cpu_ack, dma_ack} !== {~sb_e.is_dma, sb_e.is_dma}) begin
          n_err++;
          $display("FAIL sb_ack_owner: got cpu_ack=%b dma_ack=%b, required dma=%b", cpu_ack, dma_ack, sb_e.is_dma);
        end
        if (!sb_e.we) begin
          n_cmp++;
          sb_got = sb_e.is_dma ? dma_rdata : cpu_rdata;
          if (sb_got !== sb_e.rdata) begin
            n_err++;
            $display("FAIL sb_rdata: got %h, required %h", sb_got, sb_e.rdata);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_adr = '0; dma_wdata = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({cpu_ack, dma_ack, mem_read, mem_write, grant_dma, busy,
           cpu_rdata, dma_rdata, mem_adr, mem_wdata} !== '0) begin
        n_err++;
        $display("FAIL reset_idle c%0d: got ack=%b%b rd=%b wr=%b gd=%b busy=%b cr=%h dr=%h adr=%h wd=%h, required all 0",
                 c, cpu_ack, dma_ack, mem_read, mem_write, grant_dma, busy,
                 cpu_rdata, dma_rdata, mem_adr, mem_wdata);
      end
      if (c == 1) rst = 1'b1;
    end
  endtask

  task automatic test_cpu_read();
    logic [4:0] exp [0:3];
    // {mem_read, mem_write, cpu_ack, dma_ack, busy}
    exp = '{5'b00000, 5'b10001, 5'b00101, 5'b00000};
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 0) begin
        cpu_req = 1; cpu_we = 0; cpu_adr = 32'h10;
        sb.push_back('{is_dma: 1'b0, we: 1'b0, rdata: ref_mem[4]});
      end
      if (c == 2) cpu_req = 0;
      @(negedge clk);
      n_cmp++;
      if ({mem_read, mem_write, cpu_ack, dma_ack, busy} !== exp[c]) begin
        n_err++;
        $display("FAIL cpu_read_ctl c%0d: got %b, required %b", c,
                 {mem_read, mem_write, cpu_ack, dma_ack, busy}, exp[c]);
      end
      if (c == 1) begin
        n_cmp++;
        if (mem_adr !== 32'h10) begin
          n_err++;
          $display("FAIL cpu_read_adr: got %h, required %h", mem_adr, 32'h10);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if (cpu_rdata !== 32'hDEADBEEF) begin
          n_err++;
          $display("FAIL cpu_read_data: got %h, required %h", cpu_rdata, 32'hDEADBEEF);
        end
      end
    end
  endtask

  task automatic test_dma_write_readback();
    for (int c = 0; c < 7; c++) begin
      step();
      if (c == 0) begin
        dma_req = 1; dma_we = 1; dma_adr = 32'h20; dma_wdata = 32'hA5;
        ref_mem[8] = 32'hA5;
        sb.push_back('{is_dma: 1'b1, we: 1'b1, rdata: '0});
      end
      if (c == 2) dma_req = 0;
      if (c == 3) begin
        cpu_req = 1; cpu_we = 0; cpu_adr = 32'h20;
        sb.push_back('{is_dma: 1'b0, we: 1'b0, rdata: ref_mem[8]});
      end
      if (c == 5) cpu_req = 0;
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if ({mem_write, mem_read, grant_dma, mem_adr, mem_wdata} !== {3'b101, 32'h20, 32'hA5}) begin
          n_err++;
          $display("FAIL dma_write_cmd: got wr=%b rd=%b gd=%b adr=%h wd=%h, required wr=1 rd=0 gd=1 adr=20 wd=a5",
                   mem_write, mem_read, grant_dma, mem_adr, mem_wdata);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if ({dma_ack, cpu_ack} !== 2'b10) begin
          n_err++;
          $display("FAIL dma_write_ack: got dma_ack=%b cpu_ack=%b, required 1 0", dma_ack, cpu_ack);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hA5) begin
          n_err++;
          $display("FAIL readback: got ack=%b data=%h, required ack=1 data=%h", cpu_ack, cpu_rdata, 32'hA5);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (dma_rdata !== 32'h0) begin
          n_err++;
          $display("FAIL dma_rdata_hold: got %h, required %h", dma_rdata, 32'h0);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0]  exp [0:9];
    logic [31:0] adr_exp;
    // {mem_read, cpu_ack, dma_ack, grant_dma, busy}
    exp = '{5'b00000, 5'b10001, 5'b01001, 5'b00000, 5'b10011,
            5'b00111, 5'b00010, 5'b10001, 5'b01001, 5'b00000};
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) begin
        cpu_req = 1; cpu_we = 0; cpu_adr = 32'h0;
        dma_req = 1; dma_we = 0; dma_adr = 32'h4;
        sb.push_back('{is_dma: 1'b0, we: 1'b0, rdata: ref_mem[0]});
        sb.push_back('{is_dma: 1'b1, we: 1'b0, rdata: ref_mem[1]});
        sb.push_back('{is_dma: 1'b0, we: 1'b0, rdata: ref_mem[0]});
      end
      if (c == 5) dma_req = 0;
      if (c == 8) cpu_req = 0;
      @(negedge clk);
      n_cmp++;
      if ({mem_read, cpu_ack, dma_ack, grant_dma, busy} !== exp[c]) begin
        n_err++;
        $display("FAIL tie_order c%0d: got %b, required %b", c,
                 {mem_read, cpu_ack, dma_ack, grant_dma, busy}, exp[c]);
      end
      if (c == 1 || c == 4 || c == 7) begin
        adr_exp = (c == 4) ? 32'h4 : 32'h0;
        n_cmp++;
        if (mem_adr !== adr_exp) begin
          n_err++;
          $display("FAIL tie_adr c%0d: got %h, required %h", c, mem_adr, adr_exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    step();
    cpu_req = 1; cpu_we = 1; cpu_adr = 32'h30; cpu_wdata = 32'h55;
    step();
    @(negedge clk);
    n_cmp++;
    if (mem_write !== 1'b1 || mem_adr !== 32'h30) begin
      n_err++;
      $display("FAIL mid_pre: got wr=%b adr=%h, required wr=1 adr=30", mem_write, mem_adr);
    end
    #2;
    rst = 1'b0;
    cpu_req = 0; cpu_we = 0;
    #1;
    n_cmp++;
    if ({busy, mem_write, cpu_ack, grant_dma, mem_adr, mem_wdata} !== '0) begin
      n_err++;
      $display("FAIL mid_async: got busy=%b wr=%b ack=%b gd=%b adr=%h wd=%h, required all 0",
               busy, mem_write, cpu_ack, grant_dma, mem_adr, mem_wdata);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL mid_noack c%0d: got ack=%b busy=%b, required 0 0", c, cpu_ack, busy);
      end
    end
    rst = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step();
      if (c == 0) begin
        cpu_req = 1; cpu_we = 0; cpu_adr = 32'h10;
        dma_req = 1; dma_we = 0; dma_adr = 32'h4;
        sb.push_back('{is_dma: 1'b0, we: 1'b0, rdata: ref_mem[4]});
        sb.push_back('{is_dma: 1'b1, we: 1'b0, rdata: ref_mem[1]});
      end
      if (c == 2) cpu_req = 0;
      if (c == 5) dma_req = 0;
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if ({mem_read, grant_dma} !== 2'b10) begin
          n_err++;
          $display("FAIL mid_first_tie: got rd=%b gd=%b, required rd=1 gd=0", mem_read, grant_dma);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if ({mem_read, grant_dma} !== 2'b11) begin
          n_err++;
          $display("FAIL mid_second_tie: got rd=%b gd=%b, required rd=1 gd=1", mem_read, grant_dma);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL mid_settle: got busy=%b, required 0", busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp [0:6];
    // {mem_read, cpu_ack, busy}
    exp = '{3'b000, 3'b101, 3'b011, 3'b000, 3'b101, 3'b011, 3'b000};
    for (int c = 0; c < 7; c++) begin
      step();
      if (c == 0) begin
        cpu_req = 1; cpu_we = 0; cpu_adr = 32'h10;
        sb.push_back('{is_dma: 1'b0, we: 1'b0, rdata: ref_mem[4]});
        sb.push_back('{is_dma: 1'b0, we: 1'b0, rdata: ref_mem[4]});
      end
      if (c == 5) cpu_req = 0;
      @(negedge clk);
      n_cmp++;
      if ({mem_read, cpu_ack, busy} !== exp[c]) begin
        n_err++;
        $display("FAIL back_to_back c%0d: got %b, required %b", c,
                 {mem_read, cpu_ack, busy}, exp[c]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    mem[0] = 32'h11111111; ref_mem[0] = 32'h11111111;
    mem[1] = 32'h22222222; ref_mem[1] = 32'h22222222;
    mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;

    test_reset();
    test_cpu_read();
    test_dma_write_readback();
    test_simultaneous();
    test_reset_mid_access();
    test_back_to_back();

    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
